// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding / hazard unit.
// fw_sel encoding and architectural register-index width.
package fwd_hazard_unit_pkg;
  localparam int REG_W            = 5;
  localparam int NREG             = 32;
  localparam int FWSEL_RF         = 0;
  localparam int FWSEL_STAGE_BASE = 1;
endpackage

// File: rtl/fwd_hazard_unit_sb_entry.sv
// One scoreboard entry: busy flag plus remaining-latency count.
// Later issue to the same register overrides an in-progress count.
module sb_entry
  import fwd_hazard_unit_pkg::*;
#(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue,
  input  logic             flush,
  input  logic [LAT_W-1:0] lat,
  output logic             busy,
  output logic [LAT_W-1:0] cnt
);

  logic             r_busy;
  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (issue) begin
      r_busy <= 1'b1;
      r_cnt  <= lat;
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - 1'b1;
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign cnt  = r_cnt;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use / long-latency stall unit.
// Define HAZ_PERF_EN to add the stall_cycles performance counter.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NSRC  = 2,
  parameter int NFW   = 2,
  parameter int LAT_W = 3,
  localparam int SELW = $clog2(NFW + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    id_valid,
  input  logic [NSRC*REG_W-1:0]   id_rs,
  input  logic [NSRC-1:0]         id_rs_used,
  input  logic [REG_W-1:0]        id_rd,
  input  logic                    id_regwrite,
  input  logic [LAT_W-1:0]        id_lat,
  input  logic                    flush,
  input  logic [NFW*REG_W-1:0]    fw_rd,
  input  logic [NFW-1:0]          fw_we,
  output logic [NSRC*SELW-1:0]    fw_sel,
  output logic                    stall,
  output logic [NREG-1:0]         sb_busy
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  logic [NREG-1:0]  w_busy;
  logic [LAT_W-1:0] w_cnt [NREG];
  logic             w_issue;
  logic             w_stall;

  assign w_busy[0] = 1'b0;
  assign w_cnt[0]  = '0;

  assign w_issue = id_valid & ~w_stall & ~flush
                 & id_regwrite & (id_rd != '0);

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk   (clk),
      .rstn  (rstn),
      .issue (w_issue && (id_rd == REG_W'(r))),
      .flush (flush),
      .lat   (id_lat),
      .busy  (w_busy[r]),
      .cnt   (w_cnt[r])
    );
  end

  // A busy entry whose count reached 0 is forwardable, so only cnt != 0 stalls.
  always_comb begin
    w_stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_valid && id_rs_used[i]
          && (id_rs[REG_W*i +: REG_W] != '0)
          && w_busy[id_rs[REG_W*i +: REG_W]]
          && (w_cnt[id_rs[REG_W*i +: REG_W]] != '0))
        w_stall = 1'b1;
    end
  end

  // Scan farthest to nearest so the nearest match is written last.
  always_comb begin
    fw_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      fw_sel[SELW*i +: SELW] = SELW'(FWSEL_RF);
      for (int k = NFW - 1; k >= 0; k--) begin
        if (fw_we[k] && id_rs_used[i]
            && (fw_rd[REG_W*k +: REG_W] != '0)
            && (fw_rd[REG_W*k +: REG_W] == id_rs[REG_W*i +: REG_W]))
          fw_sel[SELW*i +: SELW] = SELW'(FWSEL_STAGE_BASE + k);
      end
    end
  end

  assign stall   = w_stall;
  assign sb_busy = w_busy;

`ifdef HAZ_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_stall_cycles <= '0;
    else if (w_stall)
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed scenarios plus random traffic.
// Reference model tracks the cycle at which each register becomes ready.
module tb_fwd_hazard_unit;
  localparam int SELW = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        id_valid = 1'b0;
  logic [9:0]  id_rs = '0;
  logic [1:0]  id_rs_used = '0;
  logic [4:0]  id_rd = '0;
  logic        id_regwrite = 1'b0;
  logic [2:0]  id_lat = '0;
  logic        flush = 1'b0;
  logic [9:0]  fw_rd = '0;
  logic [1:0]  fw_we = '0;
  logic [3:0]  fw_sel;
  logic        stall;
  logic [31:0] sb_busy;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_lat      (id_lat),
    .flush       (flush),
    .fw_rd       (fw_rd),
    .fw_we       (fw_we),
    .fw_sel      (fw_sel),
    .stall       (stall),
    .sb_busy     (sb_busy)
`ifdef HAZ_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic        stall;
    logic [3:0]  sel;
    logic [31:0] busy;
    int          perf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // ready[r]: first cycle in which r no longer stalls; busy while cur <= ready
  int   ready[32];
  int   cur = 0;
  int   perf_m = 0;
  logic p_issue = 1'b0, p_flush = 1'b0, p_stall = 1'b0;
  int   p_rd = 0, p_lat = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  exp_t m_e;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      m_e = q.pop_front();
      chk("stall", {31'd0, stall}, {31'd0, m_e.stall});
      chk("fw_sel", {28'd0, fw_sel}, {28'd0, m_e.sel});
      chk("sb_busy", sb_busy, m_e.busy);
`ifdef HAZ_PERF_EN
      chk("stall_cycles", stall_cycles, m_e.perf);
`endif
    end
  end

  function automatic logic m_stall(input logic v, input logic [4:0] r0,
                                   input logic [4:0] r1, input logic [1:0] used);
    logic [4:0] rs [2];
    rs[0] = r0;
    rs[1] = r1;
    m_stall = 1'b0;
    for (int i = 0; i < 2; i++)
      if (v && used[i] && rs[i] != 0 && ready[rs[i]] > cur) m_stall = 1'b1;
  endfunction

  task automatic step(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                      input logic [1:0] used, input logic [4:0] rd,
                      input logic rw, input logic [2:0] lat, input logic fl,
                      input logic [4:0] f0, input logic [4:0] f1,
                      input logic [1:0] fwe, output logic st);
    exp_t       e;
    logic [4:0] rs [2];
    logic [4:0] fr [2];
    @(posedge clk);
    if (rstn) begin
      if (p_flush) begin
        for (int r = 0; r < 32; r++) ready[r] = -1;
      end else if (p_issue) begin
        ready[p_rd] = cur + 1 + p_lat;
      end
      if (p_stall) perf_m++;
    end
    cur++;
    #1;
    id_valid = v; id_rs = {r1, r0}; id_rs_used = used;
    id_rd = rd; id_regwrite = rw; id_lat = lat; flush = fl;
    fw_rd = {f1, f0}; fw_we = fwe;
    rs[0] = r0; rs[1] = r1; fr[0] = f0; fr[1] = f1;
    e.stall = m_stall(v, r0, r1, used);
    e.sel = '0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++)
        if (used[i] && fwe[k] && fr[k] != 0 && fr[k] == rs[i]) begin
          e.sel[SELW*i +: SELW] = 2'(k + 1);
          break;
        end
    e.busy = '0;
    for (int r = 1; r < 32; r++) e.busy[r] = (ready[r] >= cur);
    e.perf = perf_m;
    q.push_back(e);
    p_issue = v && !e.stall && !fl && rw && rd != 0;
    p_flush = fl; p_stall = e.stall; p_rd = int'(rd); p_lat = int'(lat);
    #1 st = stall;
  endtask

  task automatic nop();
    logic s;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [2:0] lat);
    logic s;
    step(1, 0, 0, 2'b00, rd, 1, lat, 0, 0, 0, 0, s);
  endtask

  // reader on port p of register r, held n cycles; returns stalled-cycle count
  task automatic rdr(input int p, input logic [4:0] r, input int n,
                     input logic fl_first, output int cnt);
    logic s;
    cnt = 0;
    for (int j = 0; j < n; j++) begin
      if (p == 0) step(1, r, 0, 2'b01, 0, 0, 0, fl_first && j == 0, 0, 0, 0, s);
      else        step(1, 0, r, 2'b10, 0, 0, 0, fl_first && j == 0, 0, 0, 0, s);
      if (s) cnt++;
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_busy", sb_busy, 32'd0);
    chk("rst_async_stall", {31'd0, stall}, 32'd0);
`ifdef HAZ_PERF_EN
    chk("rst_async_perf", stall_cycles, 32'd0);
`endif
    for (int r = 0; r < 32; r++) ready[r] = -1;
    perf_m = 0; p_issue = 0; p_flush = 0; p_stall = 0;
  endtask

  initial begin
    int   c;
    logic s;
    for (int r = 0; r < 32; r++) ready[r] = -1;
    #1 rstn = 1'b0;
    nop();
    step(1, 3, 0, 2'b01, 0, 0, 0, 0, 3, 0, 2'b01, s);
    nop();
    rstn = 1'b1;
    nop();

    wr(5, 1);
    step(1, 5, 0, 2'b01, 0, 0, 0, 0, 5, 0, 2'b01, s);
    c = s ? 1 : 0;
    step(1, 5, 0, 2'b01, 0, 0, 0, 0, 5, 0, 2'b01, s);
    if (s) c++;
    chk("load_use_len", c, 1);

    wr(7, 5);
    rdr(1, 7, 8, 0, c);
    chk("div_stall_len", c, 5);

    step(1, 3, 0, 2'b01, 0, 0, 0, 0, 3, 3, 2'b11, s);
    step(1, 3, 0, 2'b01, 0, 0, 0, 0, 3, 3, 2'b10, s);
    step(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b11, s);
    step(1, 3, 3, 2'b10, 0, 0, 0, 0, 0, 3, 2'b10, s);

    wr(9, 5);
    wr(9, 0);
    rdr(0, 9, 3, 0, c);
    chk("waw_no_stall", c, 0);

    wr(4, 4);
    rdr(0, 4, 1, 1, c);
    chk("flush_cycle_stall", c, 1);
    rdr(0, 4, 3, 0, c);
    chk("post_flush_stall", c, 0);

    wr(4, 4);
    nop();
    mid_reset();
    nop();
    rstn = 1'b1;
    nop();

    for (int j = 0; j < 3; j++) begin
      wr(6, 1);
      rdr(0, 6, 2, 0, c);
      chk("perf_load_use", c, 1);
    end
    mid_reset();
    nop();
    rstn = 1'b1;

    for (int n = 0; n < 600; n++) begin
      logic [2:0] lat;
      lat = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, lat, $urandom_range(0, 24) == 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), s);
      if ($urandom_range(0, 199) == 0) begin
        mid_reset();
        nop();
        rstn = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
